parity_stream_checker: RTL and testbench

//  Multi-beat parity generator/checker, successor to our 4-bit odd-parity gate.

---
 rtl/parity_pkg.sv | 18 +
 rtl/parity_stream_checker_sat_counter.sv | 33 +++
 rtl/parity_stream_checker.sv | 136 +++++++++++++
 tb/tb_parity_stream_checker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and helpers for the multi-beat parity stream checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam logic MODE_ODD  = 1'b1;
  localparam logic MODE_EVEN = 1'b0;

  // Final frame parity from the running XOR and the latched mode.
  function automatic logic frame_parity(input logic acc, input logic mode);
    return acc ^ mode;
  endfunction

endpackage

// File: rtl/parity_stream_checker_sat_counter.sv
// Saturating up-counter with clear; clear and increment together yield 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = W'(1'b1);
  localparam logic [W-1:0] MAX  = {W{1'b1}};

  logic [W-1:0] r_count;

  // Counter state: reset, clear (with same-cycle increment), saturating increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= ZERO;
    end else if (clr) begin
      r_count <= inc ? ONE : ZERO;
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/parity_stream_checker.sv
// Accumulates parity over a valid/ready frame of beats and emits one registered
// result per frame (generated parity, parity-mismatch and length-overflow flags).
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int ERRC_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              odd_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_par,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_par,
  output logic              m_par_err,
  output logic              m_len_err,
  output logic [ERRC_W-1:0] err_count,
  input  logic              err_clr
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t           r_state;
  logic             r_acc;
  logic             r_mode;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s_ready;
  logic             r_m_valid;
  logic             r_m_par;
  logic             r_m_par_err;
  logic             r_m_len_err;

  logic             w_accept;
  logic             w_out_hs;
  logic             w_beat_par;
  logic             w_acc_next;
  logic             w_mode_eff;
  logic             w_par_next;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_err_inc;

  // Per-beat parity terms; on the first beat the mode comes straight from the input.
  always_comb begin
    w_accept   = s_valid & r_s_ready;
    w_out_hs   = r_m_valid & m_ready;
    w_beat_par = ^s_data;
    w_cnt_inc  = r_cnt + ONE_CNT;
    if (r_state == IDLE) begin
      w_acc_next = w_beat_par;
      w_mode_eff = odd_mode;
    end else begin
      w_acc_next = r_acc ^ w_beat_par;
      w_mode_eff = r_mode;
    end
    w_par_next = frame_parity(w_acc_next, w_mode_eff);
    w_err_inc  = w_out_hs & (r_m_par_err | r_m_len_err);
  end

  // Frame FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= 1'b0;
      r_mode      <= MODE_EVEN;
      r_cnt       <= {CNT_W{1'b0}};
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_m_par     <= 1'b0;
      r_m_par_err <= 1'b0;
      r_m_len_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          if (w_accept) begin
            r_acc  <= w_acc_next;
            r_mode <= w_mode_eff;
            r_cnt  <= (r_state == IDLE) ? ONE_CNT : w_cnt_inc;
            if (s_last) begin
              r_state     <= RESULT;
              r_s_ready   <= 1'b0;
              r_m_valid   <= 1'b1;
              r_m_par     <= w_par_next;
              r_m_par_err <= (s_par != w_par_next);
              r_m_len_err <= 1'b0;
            end else if ((r_state == ACC) && (w_cnt_inc == MAX_CNT)) begin
              // Oversize frame: close it here, remaining beats start a new frame.
              r_state     <= RESULT;
              r_s_ready   <= 1'b0;
              r_m_valid   <= 1'b1;
              r_m_par     <= w_par_next;
              r_m_par_err <= 1'b0;
              r_m_len_err <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end
        end
        RESULT: begin
          if (w_out_hs) begin
            r_state   <= IDLE;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_m_valid <= 1'b0;
          r_s_ready <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(ERRC_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .clr   (err_clr),
    .count (err_count)
  );

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_par     = r_m_par;
  assign m_par_err = r_m_par_err;
  assign m_len_err = r_m_len_err;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Scoreboard bench: stimulus pushes hand-computed frame results, a monitor pops on handshake.
module tb_parity_stream_checker;
  import parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       odd_mode;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_par;
  logic       m_valid;
  logic       m_ready;
  logic       m_par;
  logic       m_par_err;
  logic       m_len_err;
  logic [7:0] err_count;
  logic       err_clr;

  typedef struct packed {
    logic par;
    logic perr;
    logic lerr;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  parity_stream_checker #(.DATA_W(8), .MAX_BEATS(16), .ERRC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .odd_mode  (odd_mode),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_par     (s_par),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_par     (m_par),
    .m_par_err (m_par_err),
    .m_len_err (m_len_err),
    .err_count (err_count),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every accepted result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("m_par", {31'd0, m_par}, {31'd0, e.par});
        chk("m_par_err", {31'd0, m_par_err}, {31'd0, e.perr});
        chk("m_len_err", {31'd0, m_len_err}, {31'd0, e.lerr});
      end
    end
  end

  // Drive one beat and return #1 after the edge on which it is accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic par, input logic mode);
    int waits = 0;
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    s_par    = par;
    odd_mode = mode;
    @(negedge clk);
    while (!s_ready && waits < 200) begin
      @(negedge clk);
      waits++;
    end
    if (!s_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic push(input logic par, input logic perr, input logic lerr);
    exp_t e;
    e.par  = par;
    e.perr = perr;
    e.lerr = lerr;
    sb_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] t1_data [5];
    logic       t1_par  [5];
    int         waits;
    t1_data = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h0F};
    t1_par  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; odd_mode = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    s_par = 1'b0; m_ready = 1'b1; err_clr = 1'b0;
    idle_cycles(3);
    rst = 1'b0;
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_par", {31'd0, m_par}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    // Test 1: odd mode single-beat frames, matching s_par.
    for (int i = 0; i < 5; i++) begin
      push(t1_par[i], 1'b0, 1'b0);
      send_beat(t1_data[i], 1'b1, t1_par[i], MODE_ODD);
    end
    idle_cycles(3);
    chk("t1_err_count", {24'd0, err_count}, 32'd0);

    // Test 2 + 3: even mode 3 beats with wrong s_par, result held by m_ready=0.
    m_ready = 1'b0;
    send_beat(8'hFF, 1'b0, 1'b0, MODE_EVEN);
    send_beat(8'h01, 1'b0, 1'b0, MODE_ODD);
    chk("t2_no_early_valid", {31'd0, m_valid}, 32'd0);
    push(1'b1, 1'b1, 1'b0);
    send_beat(8'h00, 1'b1, 1'b0, MODE_ODD);
    chk("t2_latency_valid", {31'd0, m_valid}, 32'd1);
    s_valid = 1'b1; s_data = 8'h01; s_last = 1'b1; s_par = 1'b0;
    for (int c = 0; c < 5; c++) begin
      idle_cycles(1);
      chk("t3_hold_valid", {31'd0, m_valid}, 32'd1);
      chk("t3_hold_par", {31'd0, m_par}, 32'd1);
      chk("t3_hold_par_err", {31'd0, m_par_err}, 32'd1);
      chk("t3_hold_s_ready", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0; s_last = 1'b0;
    m_ready = 1'b1;
    idle_cycles(1);
    chk("t3_s_ready_after", {31'd0, s_ready}, 32'd1);
    chk("t3_m_valid_after", {31'd0, m_valid}, 32'd0);
    chk("t2_err_count", {24'd0, err_count}, 32'd1);

    // Test 4: 20 beats of 8'h01, odd mode, s_last only on beat 20.
    for (int i = 1; i <= 20; i++) begin
      if (i == 16) push(1'b1, 1'b0, 1'b1);
      if (i == 20) push(1'b1, 1'b0, 1'b0);
      send_beat(8'h01, (i == 20), 1'b1, MODE_ODD);
    end
    idle_cycles(3);
    chk("t4_err_count", {24'd0, err_count}, 32'd2);

    // Test 5: 300 errored frames saturate the counter, then clear behaviour.
    for (int i = 0; i < 300; i++) begin
      push(1'b0, 1'b1, 1'b0);
      send_beat(8'h00, 1'b1, 1'b1, MODE_EVEN);
    end
    idle_cycles(3);
    chk("t5_saturate", {24'd0, err_count}, 32'd255);
    m_ready = 1'b0;
    push(1'b0, 1'b1, 1'b0);
    send_beat(8'h00, 1'b1, 1'b1, MODE_EVEN);
    err_clr = 1'b1;
    m_ready = 1'b1;
    idle_cycles(1);
    err_clr = 1'b0;
    chk("t5_clr_with_inc", {24'd0, err_count}, 32'd1);
    idle_cycles(1);
    err_clr = 1'b1;
    idle_cycles(1);
    err_clr = 1'b0;
    chk("t5_clr_alone", {24'd0, err_count}, 32'd0);

    // Test 6: reset after 3 beats discards the partial frame.
    for (int i = 0; i < 3; i++) send_beat(8'h01, 1'b0, 1'b0, MODE_ODD);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0;
    chk("t6_s_ready", {31'd0, s_ready}, 32'd1);
    chk("t6_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_m_par", {31'd0, m_par}, 32'd0);
    chk("t6_m_par_err", {31'd0, m_par_err}, 32'd0);
    chk("t6_m_len_err", {31'd0, m_len_err}, 32'd0);
    push(1'b1, 1'b0, 1'b0);
    send_beat(8'h01, 1'b1, 1'b1, MODE_EVEN);

    waits = 0;
    while (sb_q.size() != 0 && waits < 50) begin
      idle_cycles(1);
      waits++;
    end
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    chk("final_err_count", {24'd0, err_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
